alu_dec_mc: RTL and testbench

ALU_DEC_MC -- requirements
Module: alu_dec_mc

---
 rtl/alu_dec_mc.sv | 191 +++++++++++++++++++
 tb/tb_alu_dec_mc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_dec_mc.sv
// alu_dec_mc: D-stage ALU op decoder, E-stage op register and a
// multi-cycle MULT/DIV sequencer that raises the pipeline stall, the
// unit start/done pulses and the HI/LO read/write hazard.
module alu_dec_mc #(
  parameter int AW      = 8,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 34
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instrD,
  input  logic          validD,
  input  logic          stallE,
  input  logic          flushE,
  output logic [AW-1:0] aluopE,
  output logic          md_stall,
  output logic          md_start,
  output logic          md_div,
  output logic          md_signed,
  output logic          md_done,
  output logic          md_busy,
  output logic          hilo_stallD
);

  // ALU op codes; zero is the bubble, values must match the datapath
  localparam logic [AW-1:0] OP_AND   = AW'(1);
  localparam logic [AW-1:0] OP_OR    = AW'(2);
  localparam logic [AW-1:0] OP_XOR   = AW'(3);
  localparam logic [AW-1:0] OP_NOR   = AW'(4);
  localparam logic [AW-1:0] OP_SLT   = AW'(5);
  localparam logic [AW-1:0] OP_SLTU  = AW'(6);
  localparam logic [AW-1:0] OP_ADD   = AW'(7);
  localparam logic [AW-1:0] OP_ADDU  = AW'(8);
  localparam logic [AW-1:0] OP_SUB   = AW'(9);
  localparam logic [AW-1:0] OP_SUBU  = AW'(10);
  localparam logic [AW-1:0] OP_MULT  = AW'(11);
  localparam logic [AW-1:0] OP_MULTU = AW'(12);
  localparam logic [AW-1:0] OP_DIV   = AW'(13);
  localparam logic [AW-1:0] OP_DIVU  = AW'(14);
  localparam logic [AW-1:0] OP_SLL   = AW'(15);
  localparam logic [AW-1:0] OP_SLLV  = AW'(16);
  localparam logic [AW-1:0] OP_SRL   = AW'(17);
  localparam logic [AW-1:0] OP_SRLV  = AW'(18);
  localparam logic [AW-1:0] OP_SRA   = AW'(19);
  localparam logic [AW-1:0] OP_SRAV  = AW'(20);
  localparam logic [AW-1:0] OP_MFHI  = AW'(21);
  localparam logic [AW-1:0] OP_MFLO  = AW'(22);
  localparam logic [AW-1:0] OP_MTHI  = AW'(23);
  localparam logic [AW-1:0] OP_MTLO  = AW'(24);
  localparam logic [AW-1:0] OP_ANDI  = AW'(25);
  localparam logic [AW-1:0] OP_XORI  = AW'(26);
  localparam logic [AW-1:0] OP_LUI   = AW'(27);
  localparam logic [AW-1:0] OP_ORI   = AW'(28);
  localparam logic [AW-1:0] OP_ADDI  = AW'(29);
  localparam logic [AW-1:0] OP_ADDIU = AW'(30);
  localparam logic [AW-1:0] OP_SLTI  = AW'(31);
  localparam logic [AW-1:0] OP_SLTIU = AW'(32);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  logic [5:0]    op, fn;
  logic [AW-1:0] dec;
  logic          e_md, e_div, e_sgn, d_hilo;
  logic [CW-1:0] lat_m1;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          unused_ok;

  assign op        = instrD[31:26];
  assign fn        = instrD[5:0];
  // register/immediate fields are consumed by the datapath, not here
  assign unused_ok = ^instrD[25:6];

  // D-stage decode; an invalid slot decodes as a bubble
  always_comb begin
    dec = '0;
    if (validD) begin
      case (op)
        6'h00: begin
          case (fn)
            6'h00:   dec = OP_SLL;
            6'h02:   dec = OP_SRL;
            6'h03:   dec = OP_SRA;
            6'h04:   dec = OP_SLLV;
            6'h06:   dec = OP_SRLV;
            6'h07:   dec = OP_SRAV;
            6'h10:   dec = OP_MFHI;
            6'h11:   dec = OP_MTHI;
            6'h12:   dec = OP_MFLO;
            6'h13:   dec = OP_MTLO;
            6'h18:   dec = OP_MULT;
            6'h19:   dec = OP_MULTU;
            6'h1A:   dec = OP_DIV;
            6'h1B:   dec = OP_DIVU;
            6'h20:   dec = OP_ADD;
            6'h21:   dec = OP_ADDU;
            6'h22:   dec = OP_SUB;
            6'h23:   dec = OP_SUBU;
            6'h24:   dec = OP_AND;
            6'h25:   dec = OP_OR;
            6'h26:   dec = OP_XOR;
            6'h27:   dec = OP_NOR;
            6'h2A:   dec = OP_SLT;
            6'h2B:   dec = OP_SLTU;
            default: dec = '0;
          endcase
        end
        6'h08:   dec = OP_ADDI;
        6'h09:   dec = OP_ADDIU;
        6'h0A:   dec = OP_SLTI;
        6'h0B:   dec = OP_SLTIU;
        6'h0C:   dec = OP_ANDI;
        6'h0D:   dec = OP_ORI;
        6'h0E:   dec = OP_XORI;
        6'h0F:   dec = OP_LUI;
        // loads/stores use the adder for address generation
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
        6'h28, 6'h29, 6'h2B: dec = OP_ADD;
        default: dec = '0;
      endcase
    end
  end

  // E register: flush beats stall beats load; md_stall comes back via stallE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        aluopE <= '0;
    else if (flushE) aluopE <= '0;
    else if (!stallE) aluopE <= dec;
  end

  // classify the op sitting in E
  always_comb begin
    e_div  = (aluopE == OP_DIV)  || (aluopE == OP_DIVU);
    e_md   = e_div || (aluopE == OP_MULT) || (aluopE == OP_MULTU);
    e_sgn  = (aluopE == OP_MULT) || (aluopE == OP_DIV);
    lat_m1 = e_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
    d_hilo = validD && (op == 6'h00) &&
             ((fn == 6'h10) || (fn == 6'h11) || (fn == 6'h12) || (fn == 6'h13));
  end

  // sequencer state and busy counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next state: flush always returns to IDLE and drops the count
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (flushE) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: if (e_md) begin
          state_n = S_BUSY;
          cnt_n   = lat_m1;
        end
        S_BUSY: if (cnt == '0) state_n = S_DONE;
                else           cnt_n   = cnt - 1'b1;
        // the finished op stays in E while stalled; leave only when it moves
        S_DONE: if (!stallE) state_n = S_IDLE;
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // outputs; start/done are masked by flush so a cancelled op never reports
  always_comb begin
    md_busy     = (state != S_IDLE);
    md_start    = (state == S_IDLE) && e_md && !flushE;
    md_done     = (state == S_BUSY) && (cnt == '0) && !flushE;
    md_stall    = ((state == S_IDLE) && e_md) || (state == S_BUSY);
    md_div      = md_start && e_div;
    md_signed   = md_start && e_sgn;
    hilo_stallD = d_hilo && (md_busy || e_md);
  end

endmodule

// File: tb/tb_alu_dec_mc.sv
// tb_alu_dec_mc: directed vectors for decode, E register control,
// the mult/div sequencer and async reset.
module tb_alu_dec_mc;

  localparam int AW = 8;

  // expected op codes
  localparam logic [7:0] E_NOR = 8'd4,  E_ADD = 8'd7,  E_ADDU = 8'd8,
                         E_SUB = 8'd9,  E_MULT = 8'd11, E_MULTU = 8'd12,
                         E_DIV = 8'd13, E_SLL = 8'd15, E_MFHI = 8'd21,
                         E_ANDI = 8'd25, E_LUI = 8'd27, E_ADDIU = 8'd30;

  localparam logic [31:0] I_ADDU  = 32'h00430821, I_DIV  = 32'h0043001A,
                          I_DIVU  = 32'h0043001B, I_MULT = 32'h00430018,
                          I_MULTU = 32'h00430019, I_MFHI = 32'h00002010,
                          I_LUI   = 32'h3C011234;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instrD;
  logic          validD, stallE, flushE;
  logic          stall_ext, hz_en;
  logic [AW-1:0] aluopE;
  logic          md_stall, md_start, md_div, md_signed, md_done, md_busy, hilo_stallD;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] vin [12];
  logic [7:0]  vexp[12];

  always #5 clk = ~clk;

  // hazard unit stand-in: optionally feed md_stall back into stallE
  assign stallE = stall_ext | (hz_en & md_stall);

  alu_dec_mc #(.AW(AW), .MUL_LAT(2), .DIV_LAT(4)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .validD(validD),
    .stallE(stallE), .flushE(flushE), .aluopE(aluopE),
    .md_stall(md_stall), .md_start(md_start), .md_div(md_div),
    .md_signed(md_signed), .md_done(md_done), .md_busy(md_busy),
    .hilo_stallD(hilo_stallD)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int scyc, dones, starts;

    vin[0]  = 32'h00430821; vexp[0]  = E_ADDU;
    vin[1]  = 32'h8CC50004; vexp[1]  = E_ADD;
    vin[2]  = 32'hFC000000; vexp[2]  = 8'd0;
    vin[3]  = 32'h00851027; vexp[3]  = E_NOR;
    vin[4]  = I_LUI;        vexp[4]  = E_LUI;
    vin[5]  = 32'hAC000000; vexp[5]  = E_ADD;
    vin[6]  = 32'h00000001; vexp[6]  = 8'd0;
    vin[7]  = 32'h00041080; vexp[7]  = E_SLL;
    vin[8]  = 32'h2401FFFF; vexp[8]  = E_ADDIU;
    vin[9]  = 32'h00430822; vexp[9]  = E_SUB;
    vin[10] = 32'hA0000000; vexp[10] = E_ADD;
    vin[11] = 32'h30000001; vexp[11] = E_ANDI;

    rst = 1'b0; validD = 1'b1; instrD = I_ADDU;
    flushE = 1'b0; stall_ext = 1'b0; hz_en = 1'b0;

    // held in reset across an edge: everything stays zero
    cyc();
    chk("rst_aluop", aluopE, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_stall", md_stall, 0);
    chk("rst_start", md_start, 0);
    chk("rst_hilo", hilo_stallD, 0);

    // first decode on the first edge after release
    rst = 1'b1;
    cyc();
    chk("first_addu", aluopE, E_ADDU);
    chk("first_stall", md_stall, 0);

    for (int i = 0; i < 12; i++) begin
      instrD = vin[i];
      cyc();
      chk($sformatf("dec%0d", i), aluopE, vexp[i]);
    end
    validD = 1'b0; instrD = I_ADDU;
    cyc();
    chk("dec_invalid", aluopE, 0);

    // divide with stall fed back
    hz_en = 1'b1; validD = 1'b1; instrD = I_DIV;
    cyc();
    chk("div_in_e", aluopE, E_DIV);
    instrD = I_ADDU;
    #1;
    chk("div_start", md_start, 1);
    chk("div_isdiv", md_div, 1);
    chk("div_signed", md_signed, 1);
    scyc = 0; dones = 0; starts = 0;
    for (int i = 0; i < 20; i++) begin
      if (md_stall) scyc++;
      if (md_done) begin dones++; chk("div_done_pos", scyc, 5); end
      if (md_start) starts++;
      if (!md_stall) break;
      cyc();
    end
    chk("div_stall_cyc", scyc, 5);
    chk("div_dones", dones, 1);
    chk("div_starts", starts, 1);
    chk("div_done_busy", md_busy, 1);
    chk("div_done_hold", aluopE, E_DIV);
    cyc();
    chk("div_advance", aluopE, E_ADDU);
    chk("div_idle", md_busy, 0);

    // HI/LO hazard during busy, then flush at the last busy cycle
    instrD = I_DIV;
    cyc();
    instrD = I_MFHI;
    #1;
    chk("hilo_e_md", hilo_stallD, 1);
    cyc();
    chk("hilo_busy", hilo_stallD, 1);
    chk("flush_busy", md_busy, 1);
    cyc(); cyc(); cyc();
    flushE = 1'b1;
    #1;
    chk("flush_nodone", md_done, 0);
    cyc();
    chk("flush_idle", md_busy, 0);
    chk("flush_aluop", aluopE, 0);
    chk("flush_hilo", hilo_stallD, 0);
    flushE = 1'b0; validD = 1'b0;
    cyc();

    // mult finishes, external stall holds DONE, then back-to-back multu
    validD = 1'b1; instrD = I_MULT;
    cyc();
    instrD = I_MULTU;
    #1;
    chk("mul_start", md_start, 1);
    chk("mul_isdiv", md_div, 0);
    chk("mul_signed", md_signed, 1);
    cyc(); cyc();
    chk("mul_done", md_done, 1);
    stall_ext = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_busy%0d", i), md_busy, 1);
      chk($sformatf("hold_start%0d", i), md_start, 0);
      chk($sformatf("hold_stall%0d", i), md_stall, 0);
      chk($sformatf("hold_op%0d", i), aluopE, E_MULT);
      cyc();
    end
    stall_ext = 1'b0;
    cyc();
    chk("b2b_op", aluopE, E_MULTU);
    chk("b2b_start", md_start, 1);
    chk("b2b_unsigned", md_signed, 0);
    chk("b2b_stall", md_stall, 1);
    flushE = 1'b1;
    #1;
    chk("flush_nostart", md_start, 0);
    cyc();
    flushE = 1'b0; validD = 1'b0;
    cyc();

    // stall holds E; flush together with stall clears it
    hz_en = 1'b0; validD = 1'b1; instrD = I_ADDU;
    cyc();
    stall_ext = 1'b1; instrD = I_LUI;
    cyc();
    chk("stall_hold", aluopE, E_ADDU);
    flushE = 1'b1;
    cyc();
    chk("stall_flush", aluopE, 0);
    flushE = 1'b0; stall_ext = 1'b0; validD = 1'b0;
    cyc();

    // async reset in the middle of a divide
    hz_en = 1'b1; validD = 1'b1; instrD = I_DIVU;
    cyc();
    validD = 1'b0;
    cyc();
    chk("arst_pre_busy", md_busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_aluop", aluopE, 0);
    chk("arst_busy", md_busy, 0);
    chk("arst_stall", md_stall, 0);
    #2;
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (md_done) dones++;
    end
    chk("arst_nodone", dones, 0);
    chk("arst_idle", md_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
